// File: rtl/sad_best_match_pkg.sv
// Shared types and default sizes for the SAD best-match sequencer.
package sad_best_match_pkg;

  localparam int SAD_W_DEF  = 16;
  localparam int N_CAND_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/sad_best_match_if.sv
// SAD-core request/result path plus the best-match output handshake.
interface sad_best_match_if
  import sad_best_match_pkg::*;
#(
  parameter int SAD_W  = SAD_W_DEF,
  parameter int N_CAND = N_CAND_DEF
);
  localparam int IDX_W = $clog2(N_CAND);

  // Handshake: best_valid rises in DONE and stays high with best_sad/best_idx
  // frozen until the cycle best_ready is sampled high; that edge completes
  // the transfer. sad_valid is a one-cycle strobe with no back-pressure.
  logic             sad_enb;
  logic [IDX_W-1:0] cand_idx;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;
  logic             best_valid;
  logic             best_ready;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;

  modport master (
    output sad_enb, cand_idx, best_valid, best_sad, best_idx,
    input  sad_valid, sad, best_ready
  );

  modport slave (
    input  sad_enb, cand_idx, best_valid, best_sad, best_idx,
    output sad_valid, sad, best_ready
  );

endinterface

// File: rtl/sad_best_match.sv
// Steps through N_CAND SAD evaluations and reports the lowest SAD and its index.
module sad_best_match
  import sad_best_match_pkg::*;
#(
  parameter int SAD_W  = SAD_W_DEF,
  parameter int N_CAND = N_CAND_DEF
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   start_i,
  input  logic   abort_i,
  output logic   busy_o,
  output state_t state_o,
  sad_best_match_if.master bus
);

  localparam int IDX_W = $clog2(N_CAND);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [SAD_W-1:0] sad_q;
  logic [SAD_W-1:0] best_sad_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             running;
  logic             is_last;

  assign running = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_CMP);
  assign is_last = (cnt_q == LAST_IDX);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_REQ;
      ST_REQ:  state_d = abort_i ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort_i)        state_d = ST_IDLE;
        else if (bus.sad_valid) state_d = ST_CMP;
      end
      ST_CMP: begin
        if (abort_i)      state_d = ST_IDLE;
        else if (is_last) state_d = ST_DONE;
        else              state_d = ST_REQ;
      end
      ST_DONE: if (bus.best_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // An abort discards the compare of that cycle; the first candidate always
  // seeds the best registers, later ones replace it only when strictly lower.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= '0;
      sad_q      <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else if (running && abort_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) cnt_q <= '0;
        ST_WAIT: if (bus.sad_valid) sad_q <= bus.sad;
        ST_CMP: begin
          if ((cnt_q == '0) || (sad_q < best_sad_q)) begin
            best_sad_q <= sad_q;
            best_idx_q <= cnt_q;
          end
          if (!is_last) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sad_enb    = (state_q == ST_REQ);
  assign bus.cand_idx   = cnt_q;
  assign bus.best_valid = (state_q == ST_DONE);
  assign bus.best_sad   = best_sad_q;
  assign bus.best_idx   = best_idx_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign state_o        = state_q;

endmodule

// File: tb/tb_sad_best_match.sv
// Directed bench for sad_best_match with N_CAND=4 and a 3-cycle SAD core model.
module tb_sad_best_match;
  import sad_best_match_pkg::*;

  typedef struct packed {
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] exp_sad;
    logic [1:0]  exp_idx;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic   abort = 1'b0;
  logic   busy;
  state_t state;

  sad_best_match_if #(.SAD_W(16), .N_CAND(4)) bus ();

  sad_best_match #(.SAD_W(16), .N_CAND(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .abort_i (abort),
    .busy_o  (busy),
    .state_o (state),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // SAD core model: answers 3 cycles after each sad_enb with the value for that candidate
  logic [15:0] cur_sads [4];
  logic        model_on = 1'b1;
  int          cd = 0;
  logic        mdl_valid = 1'b0;
  logic [15:0] mdl_sad = '0;
  logic [15:0] pend_sad = '0;
  logic        stray_valid = 1'b0;
  logic [15:0] stray_sad = '0;
  int          enb_cnt = 0;

  always @(negedge clk) begin
    mdl_valid = 1'b0;
    if (!rst_n) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mdl_valid = 1'b1;
          mdl_sad   = pend_sad;
        end
      end
      if (bus.sad_enb && model_on) begin
        cd       = 3;
        pend_sad = cur_sads[bus.cand_idx];
      end
    end
    if (bus.sad_enb) enb_cnt++;
  end

  assign bus.sad_valid = mdl_valid | stray_valid;
  assign bus.sad       = stray_valid ? stray_sad : mdl_sad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_state(input state_t s, input logic [1:0] idx, input string name);
    int k;
    k = 0;
    while (!(state == s && bus.cand_idx == idx) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      $display("FAIL %s: timeout waiting for state %0d idx %0d, got state %0d", name, s, idx, state);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, b, c, d, es, input logic [1:0] ei);
    vec_t v;
    v.s0 = a; v.s1 = b; v.s2 = c; v.s3 = d;
    v.exp_sad = es; v.exp_idx = ei;
    return v;
  endfunction

  // Load candidates, pulse start, check first-request latency; returns in REQ of cand 0
  task automatic launch(input vec_t v);
    cur_sads[0] = v.s0; cur_sads[1] = v.s1; cur_sads[2] = v.s2; cur_sads[3] = v.s3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("enb_latency", {31'd0, bus.sad_enb}, 32'd1);
    chk("first_idx", {30'd0, bus.cand_idx}, 32'd0);
  endtask

  task automatic accept();
    bus.best_ready = 1'b1;
    @(negedge clk);
    bus.best_ready = 1'b0;
    chk("accept_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_busy"},  {31'd0, busy}, 32'd0);
    chk({name, "_valid"}, {31'd0, bus.best_valid}, 32'd0);
    chk({name, "_enb"},   {31'd0, bus.sad_enb}, 32'd0);
    chk({name, "_sad"},   {16'd0, bus.best_sad}, 32'd0);
    chk({name, "_idx"},   {30'd0, bus.best_idx}, 32'd0);
    chk({name, "_cand"},  {30'd0, bus.cand_idx}, 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int          enb_base;
    logic [15:0] held_sad;
    logic [1:0]  held_idx;
    logic        ok;

    vecs[0] = mk(16'd500,   16'd120,   16'd900,   16'd300,   16'd120,   2'd1);
    vecs[1] = mk(16'd70,    16'd70,    16'd70,    16'd70,    16'd70,    2'd0);
    vecs[2] = mk(16'd9,     16'd10,    16'd3,     16'd3,     16'd3,     2'd2);
    vecs[3] = mk(16'd0,     16'hFFFF,  16'd0,     16'd0,     16'd0,     2'd0);
    vecs[4] = mk(16'd1000,  16'd999,   16'd998,   16'd997,   16'd997,   2'd3);
    vecs[5] = mk(16'hFFFF,  16'hFFFE,  16'hFFFF,  16'hFFFE,  16'hFFFE,  2'd1);
    bus.best_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {29'd0, state}, {29'd0, ST_IDLE});

    // table-driven searches
    for (int i = 0; i < 6; i++) begin
      enb_base = enb_cnt;
      launch(vecs[i]);
      wait_state(ST_CMP, 2'd3, "wait_last_cmp");
      @(negedge clk);
      chk("done_latency", {31'd0, bus.best_valid}, 32'd1);
      chk("best_sad", {16'd0, bus.best_sad}, {16'd0, vecs[i].exp_sad});
      chk("best_idx", {30'd0, bus.best_idx}, {30'd0, vecs[i].exp_idx});
      chk("enb_pulses", enb_cnt - enb_base, 32'd4);
      accept();
    end

    // held result under back-pressure, then accept with start high
    launch(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd5, 16'd5, 2'd3));
    wait_state(ST_DONE, 2'd3, "wait_done_hold");
    chk("hold_sad", {16'd0, bus.best_sad}, 32'd5);
    chk("hold_idx", {30'd0, bus.best_idx}, 32'd3);
    held_sad = bus.best_sad;
    held_idx = bus.best_idx;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.best_valid || bus.best_sad != held_sad || bus.best_idx != held_idx) ok = 1'b0;
    end
    chk("hold_stable", {31'd0, ok}, 32'd1);
    start = 1'b1;
    accept();
    chk("accept_start_ignored", {29'd0, state}, {29'd0, ST_IDLE});
    @(negedge clk);
    start = 1'b0;
    chk("restart_req", {29'd0, state}, {29'd0, ST_REQ});
    wait_state(ST_DONE, 2'd3, "wait_done_restart");
    chk("restart_sad", {16'd0, bus.best_sad}, 32'd5);
    accept();

    // abort in WAIT of candidate 2; the stale result then lands in IDLE
    launch(mk(16'd50, 16'd40, 16'd30, 16'd20, 16'd20, 2'd3));
    wait_state(ST_WAIT, 2'd2, "wait_abort_point");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {29'd0, state}, {29'd0, ST_IDLE});
    chk("abort_busy", {31'd0, busy}, 32'd0);
    held_sad = bus.best_sad;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (state != ST_IDLE || bus.best_valid || bus.best_sad != held_sad) ok = 1'b0;
    end
    chk("stray_in_idle", {31'd0, ok}, 32'd1);

    // stray strobe in REQ must not advance to CMP
    model_on = 1'b0;
    launch(mk(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 2'd0));
    stray_valid = 1'b1;
    stray_sad   = 16'd1;
    @(negedge clk);
    stray_valid = 1'b0;
    chk("stray_in_req", {29'd0, state}, {29'd0, ST_WAIT});
    repeat (2) @(negedge clk);
    chk("wait_holds", {29'd0, state}, {29'd0, ST_WAIT});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort2_idle", {29'd0, state}, {29'd0, ST_IDLE});
    model_on = 1'b1;

    // full search after aborts
    launch(vecs[0]);
    wait_state(ST_DONE, 2'd3, "wait_done_post_abort");
    chk("post_abort_sad", {16'd0, bus.best_sad}, 32'd120);
    chk("post_abort_idx", {30'd0, bus.best_idx}, 32'd1);
    accept();

    // asynchronous reset in the CMP of candidate 1
    launch(mk(16'd400, 16'd300, 16'd200, 16'd100, 16'd100, 2'd3));
    wait_state(ST_CMP, 2'd1, "wait_cmp_reset");
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    chk("async_rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    launch(vecs[2]);
    wait_state(ST_DONE, 2'd3, "wait_done_post_rst");
    chk("post_rst_sad", {16'd0, bus.best_sad}, 32'd3);
    chk("post_rst_idx", {30'd0, bus.best_idx}, 32'd2);
    accept();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
